// File: rtl/fib_seq_pkg.sv
// Shared definitions for the Fibonacci sequencer and the lab ALU it drives:
// widths, ALU opcodes, flag bit positions and the sequencer state encoding.
package fib_seq_pkg;

   localparam int OPERAND_W = 6;
   localparam int OPCODE_W  = 3;

   typedef enum logic [OPCODE_W-1:0] {
      EXE_ADD,
      EXE_SUB,
      EXE_AND,
      EXE_OR,
      EXE_XOR,
      EXE_NOT,
      EXE_SHL,
      EXE_SHR
   } exe_op_t;

   localparam int F_CARRY = 2;
   localparam int F_OVF   = 1;
   localparam int F_ZERO  = 0;

   typedef enum logic [2:0] {
      IDLE,
      EMIT0,
      EMIT1,
      ISSUE,
      CAPTURE,
      EMITN
   } state_t;

endpackage

// File: rtl/fib_seq_if.sv
// Valid/ready term stream from the sequencer to the display or top-level logic.
interface fib_seq_if
   import fib_seq_pkg::*;
   #(parameter int W = OPERAND_W)
   ();

   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/fib_seq.sv
// Fibonacci sequencer: emits two seed terms, then repeatedly adds the last two
// terms through the registered lab ALU and streams each sum out.
module fib_seq
   import fib_seq_pkg::*;
   #(
      parameter int W   = OPERAND_W,
      parameter int OPW = OPCODE_W
   )
   (
      input  logic           clk,
      input  logic           rst,
      input  logic           start,
      input  logic [W-1:0]   f0,
      input  logic [W-1:0]   f1,
      input  logic [7:0]     count,
      output logic [OPW-1:0] alu_op,
      output logic [W-1:0]   alu_a,
      output logic [W-1:0]   alu_b,
      input  logic [W-1:0]   alu_c,
      input  logic [OPW-1:0] alu_f,
      fib_seq_if.master      out_s,
      output logic           busy,
      output logic           done,
      output logic           ovf
   );

   state_t       state_q, state_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [7:0]   rem_q, rem_d;
   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;
   logic         done_q, done_d;
   logic         ovf_q, ovf_d;
   logic         accept;
   logic         unused_flags;

   assign alu_op = OPW'(EXE_ADD);
   assign alu_a  = a_q;
   assign alu_b  = b_q;

   assign out_s.data  = data_q;
   assign out_s.valid = valid_q;

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign ovf  = ovf_q;

   assign accept = valid_q && out_s.ready;

   // Only the carry matters; signed overflow and zero are don't-cares here.
   assign unused_flags = ^{alu_f[F_OVF], alu_f[F_ZERO]};

   always_comb begin
      // NOTE: every output of this block gets a default before the case, so no
      // path leaves a signal unassigned and no latch is inferred.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;

      unique case (state_q)
         IDLE: begin
            // A start coinciding with the done pulse belongs to the old run.
            if (start && !done_q) begin
               a_d     = f0;
               b_d     = f1;
               rem_d   = count;
               ovf_d   = 1'b0;
               data_d  = f0;
               valid_d = 1'b1;
               state_d = EMIT0;
            end
         end

         EMIT0: begin
            if (accept) begin
               data_d  = b_q;
               state_d = EMIT1;
            end
         end

         EMIT1, EMITN: begin
            if (accept) begin
               valid_d = 1'b0;
               if (rem_q == 8'd0) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end

         // a/b stay put here and in CAPTURE so the free-running ALU result is
         // still a+b when CAPTURE samples it one edge later.
         ISSUE: begin
            state_d = CAPTURE;
         end

         CAPTURE: begin
            data_d  = alu_c;
            valid_d = 1'b1;
            a_d     = b_q;
            b_d     = alu_c;
            rem_d   = rem_q - 8'd1;
            ovf_d   = ovf_q | alu_f[F_CARRY];
            state_d = EMITN;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values,
         // independent of statement order.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   ast_stall_hold: assert property (@(posedge clk) disable iff (rst)
      (out_s.valid && !out_s.ready) |=> (out_s.valid && $stable(out_s.data)));

   ast_done_pulse: assert property (@(posedge clk) disable iff (rst)
      done |=> !done);

   ast_issue_capture: assert property (@(posedge clk) disable iff (rst)
      (state_q == ISSUE) |=> (state_q == CAPTURE));

   ast_idle_quiet: assert property (@(posedge clk) disable iff (rst)
      !busy |-> !out_s.valid);

endmodule
